// File: rtl/encoder4_pkg.sv
// encoder4_pkg: shared definitions for the serial pattern encoder and the
// matching decoder/benches.
//   - state_e     : encoder FSM state encoding (S_IDLE .. S_GAP)
//   - DEF_*       : default pattern width, payload width and gap length
//   - max3()      : helper used to size the shared bit counter
package encoder4_pkg;

  localparam int DEF_PAT_W  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_GAP    = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_ARMED = 3'd2,
    S_SYNC  = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/encoder4_if.sv
// encoder4_if: request/response bundle between a stimulus master and the
// encoder.
//   pattern/load : pattern to program and its request
//   data/send    : payload word and frame request
//   prgm/sig     : serial bits toward the decoder
//   busy/programmed/done : encoder status
// Modports: master drives requests, slave (the encoder) drives serial/status.
interface encoder4_if
  import encoder4_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [PAT_W-1:0]  pattern;
  logic              load;
  logic [DATA_W-1:0] data;
  logic              send;
  logic              prgm;
  logic              sig;
  logic              busy;
  logic              programmed;
  logic              done;

  modport master (
    output pattern, load, data, send,
    input  prgm, sig, busy, programmed, done
  );

  modport slave (
    input  pattern, load, data, send,
    output prgm, sig, busy, programmed, done
  );

endinterface

// File: rtl/encoder4_piso_shift.sv
// encoder4_piso_shift: parallel-in / serial-out shifter, MSB first.
//   clk, clr    : clock and async active-high clear
//   ld_i, din_i : parallel load (has priority over shift)
//   sh_i        : shift left by one, zero fill
//   msb_nxt_o   : MSB the register will hold after the coming edge; lets the
//                 owner register its serial output in the same cycle the
//                 shifter updates.
module encoder4_piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld_i,
  input  logic         sh_i,
  input  logic [W-1:0] din_i,
  output logic         msb_nxt_o
);

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (ld_i)      sreg_d = din_i;
    else if (sh_i) sreg_d = sreg_q << 1;
  end

  assign msb_nxt_o = sreg_d[W-1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

endmodule

// File: rtl/encoder4.sv
// encoder4: serial pattern transmitter feeding a decoder's prgm/sig inputs.
// Programs a PAT_W-bit match pattern on prgm, then on request emits frames
// on sig: sync pattern, payload MSB first, GAP idle zero bits.
//   clk : clock, all state changes on posedge
//   clr : asynchronous active-high reset
//   bus : encoder4_if.slave (pattern/load, data/send in; prgm/sig,
//         busy/programmed/done out, all registered)
module encoder4
  import encoder4_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic      clk,
  input  logic      clr,
  encoder4_if.slave bus
);

  localparam int CNT_W = $clog2(max3(PAT_W, DATA_W, GAP) + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q;
  logic             prgm_q, sig_q, busy_q, done_q, programmed_q;

  logic             last_c, frame_end_c, acc_load_c, start_c;
  logic             pat_ld_c, pat_sh_c, dat_sh_c;
  logic [PAT_W-1:0] pat_din_c;
  logic             pat_msb_nxt, dat_msb_nxt;

  // Index of the final cycle of the field the state is emitting.
  function automatic cnt_t field_last(input state_e s);
    case (s)
      S_PROG, S_SYNC: return cnt_t'(PAT_W - 1);
      S_DATA:         return cnt_t'(DATA_W - 1);
      S_GAP:          return cnt_t'((GAP > 0) ? GAP - 1 : 0);
      default:        return '0;
    endcase
  endfunction

  // True for the last cycle of a frame (done cycle).
  function automatic logic frame_last(input state_e s, input cnt_t c);
    if (GAP > 0) return (s == S_GAP)  && (c == field_last(S_GAP));
    else         return (s == S_DATA) && (c == field_last(S_DATA));
  endfunction

  assign last_c      = (cnt_q == field_last(state_q));
  assign frame_end_c = frame_last(state_q, cnt_q);
  assign acc_load_c  = ((state_q == S_IDLE) || (state_q == S_ARMED)) && bus.load;
  // A frame starts from ARMED (load has priority) or directly off the done
  // cycle when send is still held, which makes frames back-to-back.
  assign start_c     = ((state_q == S_ARMED) && bus.send && !bus.load) ||
                       (frame_end_c && bus.send);

  // Pattern shifter serves both PROG and SYNC; reloaded from the captured
  // pattern at every frame start.
  assign pat_ld_c  = acc_load_c || start_c;
  assign pat_din_c = acc_load_c ? bus.pattern : pat_q;
  assign pat_sh_c  = (state_q == S_PROG) || (state_q == S_SYNC);
  assign dat_sh_c  = (state_q == S_DATA);

  encoder4_piso_shift #(.W(PAT_W)) u_pat_sh (
    .clk       (clk),
    .clr       (clr),
    .ld_i      (pat_ld_c),
    .sh_i      (pat_sh_c),
    .din_i     (pat_din_c),
    .msb_nxt_o (pat_msb_nxt)
  );

  encoder4_piso_shift #(.W(DATA_W)) u_dat_sh (
    .clk       (clk),
    .clr       (clr),
    .ld_i      (start_c),
    .sh_i      (dat_sh_c),
    .din_i     (bus.data),
    .msb_nxt_o (dat_msb_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (acc_load_c) state_d = S_PROG;
      end
      S_ARMED: begin
        if (acc_load_c)   state_d = S_PROG;
        else if (start_c) state_d = S_SYNC;
      end
      S_PROG: begin
        if (last_c) state_d = S_ARMED;
        else        cnt_d   = cnt_q + cnt_t'(1);
      end
      S_SYNC: begin
        if (last_c) state_d = S_DATA;
        else        cnt_d   = cnt_q + cnt_t'(1);
      end
      S_DATA: begin
        if (!last_c)     cnt_d   = cnt_q + cnt_t'(1);
        else if (GAP > 0) state_d = S_GAP;
        else             state_d = start_c ? S_SYNC : S_ARMED;
      end
      S_GAP: begin
        if (last_c) state_d = start_c ? S_SYNC : S_ARMED;
        else        cnt_d   = cnt_q + cnt_t'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each serial bit appears in
  // the cycle after the edge that selected it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      prgm_q       <= 1'b0;
      sig_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      programmed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if (acc_load_c) pat_q <= bus.pattern;
      prgm_q       <= (state_d == S_PROG) && pat_msb_nxt;
      sig_q        <= (state_d == S_SYNC) ? pat_msb_nxt :
                      (state_d == S_DATA) ? dat_msb_nxt : 1'b0;
      busy_q       <= (state_d inside {S_PROG, S_SYNC, S_DATA, S_GAP});
      done_q       <= frame_last(state_d, cnt_d);
      programmed_q <= programmed_q || ((state_q == S_PROG) && last_c);
    end
  end

  assign bus.prgm       = prgm_q;
  assign bus.sig        = sig_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.programmed = programmed_q;

endmodule

// File: tb/tb_encoder4.sv
// tb_encoder4: scoreboard bench for encoder4. Each stimulus pushes the
// per-cycle expected outputs; every cycle pops one entry and compares it.
module tb_encoder4;
  import encoder4_pkg::*;

  localparam int PAT_W  = 4;
  localparam int DATA_W = 8;
  localparam int GAP    = 2;
  localparam int F      = PAT_W + DATA_W + GAP;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  encoder4_if #(.PAT_W(PAT_W), .DATA_W(DATA_W)) bus ();

  encoder4 #(.PAT_W(PAT_W), .DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic prgm;
    logic sig;
    logic busy;
    logic done;
    logic programmed;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic p, input logic s, input logic b, input logic d, input logic pr);
    exp_t e;
    e.prgm = p; e.sig = s; e.busy = b; e.done = d; e.programmed = pr;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic pr);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, pr);
  endtask

  task automatic push_prog(input logic [PAT_W-1:0] pat, input logic pr);
    for (int i = 0; i < PAT_W; i++) push(pat[PAT_W-1-i], 1'b0, 1'b1, 1'b0, pr);
  endtask

  task automatic push_frame(input logic [PAT_W-1:0] pat, input logic [DATA_W-1:0] d);
    for (int i = 0; i < PAT_W; i++)
      push(1'b0, pat[PAT_W-1-i], 1'b1, (GAP == 0 && DATA_W == 0 && i == PAT_W-1), 1'b1);
    for (int j = 0; j < DATA_W; j++)
      push(1'b0, d[DATA_W-1-j], 1'b1, (GAP == 0 && j == DATA_W-1), 1'b1);
    for (int g = 0; g < GAP; g++)
      push(1'b0, 1'b0, 1'b1, (g == GAP-1), 1'b1);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("prgm@%0d", cyc),       bus.prgm,       e.prgm);
      chk($sformatf("sig@%0d", cyc),        bus.sig,        e.sig);
      chk($sformatf("busy@%0d", cyc),       bus.busy,       e.busy);
      chk($sformatf("done@%0d", cyc),       bus.done,       e.done);
      chk($sformatf("programmed@%0d", cyc), bus.programmed, e.programmed);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clr         = 1'b1;
    bus.pattern = '0;
    bus.load    = 1'b0;
    bus.data    = '0;
    bus.send    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_prgm", bus.prgm, 0);
    chk("rst_sig", bus.sig, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_programmed", bus.programmed, 0);
    @(negedge clk);
    clr = 1'b0;

    // send before any load is ignored
    bus.data = 8'hFF; bus.send = 1'b1;
    push_idle(20, 1'b0);
    run(20);
    bus.send = 1'b0;

    // program 1010
    bus.pattern = 4'b1010; bus.load = 1'b1;
    push_prog(4'b1010, 1'b0);
    push_idle(2, 1'b1);
    cycle();
    bus.load = 1'b0;
    run(PAT_W - 1 + 2);

    // single frame 0x81
    bus.data = 8'h81; bus.send = 1'b1;
    push_frame(4'b1010, 8'h81);
    push_idle(1, 1'b1);
    cycle();
    bus.send = 1'b0;
    run(F);

    // load/send during SYNC are ignored
    bus.data = 8'h3C; bus.send = 1'b1;
    push_frame(4'b1010, 8'h3C);
    push_idle(1, 1'b1);
    cycle();
    bus.send = 1'b0;
    cycle();
    bus.pattern = 4'b0110; bus.load = 1'b1; bus.send = 1'b1; bus.data = 8'hE7;
    cycle();
    bus.load = 1'b0; bus.send = 1'b0;
    run(F - 3 + 1);

    // next frame still uses the original pattern
    bus.data = 8'h5A; bus.send = 1'b1;
    push_frame(4'b1010, 8'h5A);
    push_idle(1, 1'b1);
    cycle();
    bus.send = 1'b0;
    run(F);

    // back-to-back frames with send held across the done cycle
    bus.data = 8'h00; bus.send = 1'b1;
    push_frame(4'b1010, 8'h00);
    push_frame(4'b1010, 8'hA0);
    push_idle(2, 1'b1);
    cycle();
    bus.data = 8'hA0;
    run(F);
    bus.send = 1'b0;
    run(F - 1 + 2);

    // load and send together in ARMED: reprogram wins, send dropped
    bus.pattern = 4'b0011; bus.load = 1'b1; bus.send = 1'b1; bus.data = 8'hFF;
    push_prog(4'b0011, 1'b1);
    push_idle(2, 1'b1);
    cycle();
    bus.load = 1'b0; bus.send = 1'b0;
    run(PAT_W + 1);

    // frame with new pattern, cut by clr in the middle of DATA
    bus.data = 8'hFF; bus.send = 1'b1;
    push_frame(4'b0011, 8'hFF);
    cycle();
    bus.send = 1'b0;
    run(PAT_W + 2);
    sb_q.delete();
    clr = 1'b1;
    #1;
    chk("clr_sig", bus.sig, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_programmed", bus.programmed, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_prgm", bus.prgm, 0);
    @(negedge clk);
    clr = 1'b0;

    // after clr a send is ignored until reprogrammed
    bus.send = 1'b1;
    push_idle(20, 1'b0);
    run(20);
    bus.send = 1'b0;

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
